// File: rtl/des_sbox_sched.sv
// DES S-box lookup sequencer: one shared synchronous ROM bank,
// eight lookups per word, 32-bit pre-P result over valid/ready.
module des_sbox_sched #(
  parameter int ROM_LAT = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [47:0] in_data,
  output logic        rom_en,
  output logic [2:0]  rom_sel,
  output logic [1:0]  rom_row,
  output logic [3:0]  rom_col,
  input  logic [3:0]  rom_dout,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [47:0] held;
  logic [2:0]  k;
  logic [5:0]  chunks [8];
  logic [5:0]  chunk;

  logic [2:0]  sel_q;
  logic [1:0]  row_q;
  logic [3:0]  col_q;

  logic [ROM_LAT-1:0] pv;
  logic [2:0]         pidx [ROM_LAT];
  logic               cap;
  logic [2:0]         cap_idx;

  for (genvar i = 0; i < 8; i++) begin : g_chunk
    assign chunks[i] = held[47-6*i -: 6];
  end

  assign chunk   = chunks[k];
  assign cap     = pv[ROM_LAT-1];
  assign cap_idx = pidx[ROM_LAT-1];

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign rom_en    = (state == ISSUE);

  // Address lines follow the live chunk while issuing, else hold.
  assign rom_sel = rom_en ? k : sel_q;
  assign rom_row = rom_en ? {chunk[5], chunk[0]} : row_q;
  assign rom_col = rom_en ? chunk[4:1] : col_q;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (in_valid) state_nx = ISSUE;
      ISSUE: if (k == 3'd7) state_nx = DRAIN;
      DRAIN: if (cap && cap_idx == 3'd7) state_nx = DONE;
      DONE:  if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      held  <= '0;
      k     <= '0;
      sel_q <= '0;
      row_q <= '0;
      col_q <= '0;
    end else begin
      if (state == IDLE && in_valid) begin
        held <= in_data;
        k    <= '0;
      end
      if (rom_en) begin
        k     <= k + 3'd1;
        sel_q <= rom_sel;
        row_q <= rom_row;
        col_q <= rom_col;
      end
    end
  end

  // Tracks each lookup until its ROM data is due.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pv <= '0;
      for (int i = 0; i < ROM_LAT; i++) begin
        pidx[i] <= '0;
      end
    end else begin
      pv[0]   <= rom_en;
      pidx[0] <= k;
      for (int i = 1; i < ROM_LAT; i++) begin
        pv[i]   <= pv[i-1];
        pidx[i] <= pidx[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_data <= '0;
    end else if (cap) begin
      for (int j = 0; j < 8; j++) begin
        if (cap_idx == 3'(j)) begin
          out_data[31-4*j -: 4] <= rom_dout;
        end
      end
    end
  end

endmodule

// File: tb/tb_des_sbox_sched.sv
// Directed bench: ROM_LAT=1 and ROM_LAT=2 instances share stimulus,
// each backed by its own S-box ROM model.
module tb_des_sbox_sched;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic [47:0] in_data;
  logic        out_ready;

  logic        a_in_ready, b_in_ready;
  logic        a_rom_en, b_rom_en;
  logic [2:0]  a_rom_sel, b_rom_sel;
  logic [1:0]  a_rom_row, b_rom_row;
  logic [3:0]  a_rom_col, b_rom_col;
  logic [3:0]  a_rom_dout, b_rom_dout;
  logic        a_out_valid, b_out_valid;
  logic [31:0] a_out_data, b_out_data;
  logic        a_busy, b_busy;

  int checks = 0;
  int failures = 0;

  localparam logic [63:0] SBT [32] = '{
    64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538,
    64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
    64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5,
    64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
    64'hA09E63F51DC7B428, 64'hD70934A6285ECBF1,
    64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
    64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9,
    64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
    64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986,
    64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
    64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38,
    64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
    64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86,
    64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
    64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92,
    64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
  };

  function automatic logic [3:0] sbox(input logic [2:0] s,
                                      input logic [1:0] r,
                                      input logic [3:0] c);
    logic [63:0] w;
    int ci;
    w  = SBT[{s, r}];
    ci = int'(c);
    return w[63-4*ci -: 4];
  endfunction

  logic [3:0] a_r1, b_r1, b_r2;

  always @(posedge clk) begin
    a_r1 <= sbox(a_rom_sel, a_rom_row, a_rom_col);
    b_r1 <= sbox(b_rom_sel, b_rom_row, b_rom_col);
    b_r2 <= b_r1;
  end

  assign a_rom_dout = a_r1;
  assign b_rom_dout = b_r2;

  des_sbox_sched #(.ROM_LAT(1)) u_a (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .rom_en(a_rom_en), .rom_sel(a_rom_sel),
    .rom_row(a_rom_row), .rom_col(a_rom_col), .rom_dout(a_rom_dout),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .out_data(a_out_data), .busy(a_busy)
  );

  des_sbox_sched #(.ROM_LAT(2)) u_b (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
    .rom_en(b_rom_en), .rom_sel(b_rom_sel),
    .rom_row(b_rom_row), .rom_col(b_rom_col), .rom_dout(b_rom_dout),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .out_data(b_out_data), .busy(b_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ctl"},
        {a_in_ready, a_busy, a_out_valid, a_rom_en,
         b_in_ready, b_busy, b_out_valid, b_rom_en}, 8'b1000_1000);
    chk({tag, "_addr"},
        {a_rom_sel, a_rom_row, a_rom_col,
         b_rom_sel, b_rom_row, b_rom_col}, '0);
    chk({tag, "_data"}, {a_out_data, b_out_data}, '0);
  endtask

  // n counts edges from the acceptance edge (n=1) onwards.
  task automatic send(input logic [47:0] d, input logic [31:0] e,
                      input logic [1:0] r0, input logic [3:0] c0,
                      input bit poke);
    int la, lb, ne;
    logic [23:0] seq;
    la = 0; lb = 0; ne = 0; seq = '0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("accept_ready_busy",
        {a_in_ready, a_busy, b_in_ready, b_busy}, 4'b0101);
    chk("first_lookup",
        {a_rom_sel, a_rom_row, a_rom_col,
         b_rom_sel, b_rom_row, b_rom_col},
        {3'd0, r0, c0, 3'd0, r0, c0});
    for (int n = 1; n <= 40 && (la == 0 || lb == 0); n++) begin
      if (n > 1) begin
        @(posedge clk);
        #1;
      end
      if (a_rom_en) begin
        seq = {seq[20:0], a_rom_sel};
        ne++;
      end
      if (poke && n == 3) begin
        in_valid = 1'b1;
        in_data  = '1;
      end
      if (poke && n == 5) in_valid = 1'b0;
      if (la == 0 && a_out_valid) la = n;
      if (lb == 0 && b_out_valid) lb = n;
    end
    chk("latency_lat1", la, 10);
    chk("latency_lat2", lb, 11);
    chk("sel_sequence", seq, 24'h053977);
    chk("issue_cycles", ne, 8);
    chk("out_data_lat1", a_out_data, e);
    chk("out_data_lat2", b_out_data, e);
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("released_idle",
        {a_in_ready, a_out_valid, b_in_ready, b_out_valid}, 4'b1010);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        bad;
    logic [31:0] ha, hb;
    rstn      = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #1;
    chk_reset_outputs("reset");
    #20;
    @(negedge clk);
    rstn = 1'b1;

    send(48'h000000000000, 32'hEFA72C4D, 2'd0, 4'd0, 1'b0);
    release_out();

    send(48'h6117BA866527, 32'h5C82B597, 2'd0, 4'd12, 1'b0);
    bad = 1'b0;
    ha  = a_out_data;
    hb  = b_out_data;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (a_out_data !== ha || b_out_data !== hb) bad = 1'b1;
      if ({a_out_valid, a_in_ready, b_out_valid, b_in_ready} !== 4'b1010)
        bad = 1'b1;
    end
    chk("backpressure_hold", bad, 1'b0);
    chk("backpressure_data", {a_out_data, b_out_data},
        {32'h5C82B597, 32'h5C82B597});
    release_out();

    send(48'h000000000000, 32'hEFA72C4D, 2'd0, 4'd0, 1'b1);
    release_out();
    repeat (3) @(posedge clk);
    #1;
    chk("poke_not_accepted", {a_busy, b_busy}, 2'b00);

    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 48'h000000000000;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    chk_reset_outputs("mid_issue_reset");
    @(negedge clk);
    rstn = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("no_stale_capture",
        {a_out_data, b_out_data, a_busy, b_busy}, '0);

    send(48'h6117BA866527, 32'h5C82B597, 2'd0, 4'd12, 1'b0);
    release_out();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/des_sbox_sched.md
Name: des_sbox_sched

Overview:
- Sequencer that time-multiplexes one shared, synchronous-read S-box ROM bank across the eight S-box lookups of the DES f-function.
- Accepts a 48-bit word (E(R) xor Ki) over a valid/ready handshake.
- Issues eight {sel,row,col} lookups (S1..S8) on consecutive cycles, collects the 4-bit results and returns the 32-bit pre-P-permutation word over a second valid/ready handshake.
- Sits between the round key-mix XOR and the P permutation in the iterative round datapath.

Parameters:
- ROM_LAT, 1, read latency of the S-box ROM bank in clocks, from address to dout; legal values are 1 and 2.

Ports:
- clk  input  1  rising-edge clock
- rstn  input  1  asynchronous active-low reset
- in_valid  input  1  in_data is valid
- in_ready  output  1  block can accept a word
- in_data  input  48  S-box input word; bits [47:42] feed S1 and bits [5:0] feed S8
- rom_en  output  1  lookup issued this cycle
- rom_sel  output  3  S-box index, 0 = S1 through 7 = S8
- rom_row  output  2  row = {b1,b6} of the 6-bit chunk (b1 = chunk MSB)
- rom_col  output  4  col = b2..b5 of the chunk
- rom_dout  input  4  ROM data, valid ROM_LAT clocks after rom_en
- out_valid  output  1  out_data is valid
- out_ready  input  1  downstream accepts out_data
- out_data  output  32  S1 result in [31:28] through S8 result in [3:0]
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rstn low, asynchronous):
  - state = IDLE; issue counter and capture counter = 0; input holding register and out_data = 0.
  - in_ready = 1, out_valid = 0, rom_en = 0, rom_sel/row/col = 0, busy = 0.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - in_ready = 1.
  - When in_valid is high at a clock edge, register in_data and go to ISSUE with issue counter k = 0.
- ISSUE (exactly 8 cycles):
  - rom_en = 1, rom_sel = k, and row/col are taken from chunk k = held[47-6k : 42-6k].
  - k increments each cycle. After k = 7, go to DRAIN.
- Capture:
  - A ROM_LAT-deep valid/index shift pipeline tracks outstanding lookups.
  - When a tracked lookup matures, rom_dout is written to out_data nibble [31-4j : 28-4j], where j is that lookup's index.
  - Captures overlap issue: the first capture happens ROM_LAT cycles after the first issue.
- DRAIN:
  - rom_en = 0.
  - Stay until the last capture (j = 7) is done, which takes ROM_LAT cycles, then go to DONE.
- DONE:
  - out_valid = 1 and out_data is held stable.
  - When out_ready is high at a clock edge, go to IDLE.
  - While out_ready is low, hold indefinitely with no change.
- Latency: out_valid first goes high 9+ROM_LAT clocks after the acceptance edge (10 for ROM_LAT = 1).
- Throughput: one word every 10+ROM_LAT clocks when out_ready is held high.
- in_ready is 0 in ISSUE, DRAIN and DONE. in_valid asserted outside IDLE is ignored, and in_data is not sampled.
- in_ready depends only on state; there is no combinational path from out_ready to in_ready.
- out_data nibbles not yet captured keep their previous values. Only DONE qualifies out_data as valid.
- rom_sel/row/col hold their last values when rom_en = 0; the ROM is read every cycle, so consumers ignore dout unless it is tracked.
- Reset asserted mid-ISSUE, DRAIN or DONE:
  - Immediate return to IDLE and all outputs go to their reset values.
  - In-flight lookups are discarded, and no stale capture may land after reset is released.

Test Plan:
- ROM_LAT=1, in_data=48'h000000000000 with out_ready=1 -> out_valid after exactly 10 clocks, out_data=32'hEFA72C4D.
- ROM_LAT=1, in_data=48'h6117BA866527 (FIPS round-1 vector) -> out_data=32'h5C82B597.
  - First lookup: rom_sel=0, row=0, col=12.
  - rom_sel steps 0..7 on consecutive cycles.
- ROM_LAT=2, same vector -> out_data=32'h5C82B597 with out_valid after exactly 11 clocks.
- Backpressure: out_ready=0 for 20 cycles in DONE -> out_valid and out_data stable, in_ready=0. Then raise out_ready -> IDLE on the next edge, and a second word is accepted one cycle later.
- in_valid pulsed with 48'hFFFFFFFFFFFF during ISSUE of a 48'h0 word -> ignored; result stays 32'hEFA72C4D.
- rstn pulled low asynchronously at the 4th ISSUE cycle -> outputs at reset values immediately. After release, a 48'h6117BA866527 word yields 32'h5C82B597 with no corruption.
